seg_scan_capture: RTL and testbench

//   Receive side of the 7-segment display interface: watches a multiplexed
//   4-digit display bus (active-low anodes + active-low a..g cathodes), qualifies

---
 rtl/seg_scan_capture.sv | 142 ++++++++++++++
 tb/tb_seg_scan_capture.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_capture.sv
// Receive side of a multiplexed 4-digit 7-segment bus: qualifies stable digits,
// decodes them back to BCD and publishes complete 16-bit frames.
module seg_scan_capture #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [3:0]  anode_n,
  input  logic [0:6]  LED_out,
  output logic [15:0] value,
  output logic [3:0]  digit_err,
  output logic        valid
);

  typedef enum logic {StIdle, StScan} state_e;

  localparam logic [CNT_W-1:0] StableMax = CNT_W'(STABLE_CYCLES);

  state_e            state_q, state_d;
  logic [3:0]        stage_anode_q;
  logic [0:6]        stage_seg_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        seen_q, seen_d;
  logic [15:0]       slots_q, slots_d;
  logic [3:0]        err_q, err_d;
  logic [15:0]       value_q, value_d;
  logic [3:0]        digit_err_q, digit_err_d;
  logic              valid_q, valid_d;

  logic              same;
  logic              qualify;
  logic              one_low;
  logic              write_en;
  logic              complete;
  logic [3:0]        dec;
  logic              dec_bad;

  // Incoming sample vs. held stage: a mismatch means the stage changes on this edge.
  assign same    = (anode_n == stage_anode_q) && (LED_out == stage_seg_q);
  assign qualify = same && (cnt_q == StableMax - 1'b1);
  assign one_low = ($countones(~stage_anode_q) == 1);

  assign write_en = qualify && one_low && (state_q == StScan) && enable;
  assign complete = (state_q == StScan) && enable && (seen_q == 4'hF);

  always_comb begin
    dec     = 4'hF;
    dec_bad = 1'b0;
    unique case (stage_seg_q)
      7'b0000001: dec = 4'd0;
      7'b1001111: dec = 4'd1;
      7'b0010010: dec = 4'd2;
      7'b0000110: dec = 4'd3;
      7'b1001100: dec = 4'd4;
      7'b0100100: dec = 4'd5;
      7'b0100000: dec = 4'd6;
      7'b0001111: dec = 4'd7;
      7'b0000000: dec = 4'd8;
      7'b0000100: dec = 4'd9;
      default:    dec_bad = 1'b1;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!same) begin
      cnt_d = '0;
    end else if (cnt_q != StableMax) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    seen_d      = seen_q;
    slots_d     = slots_q;
    err_d       = err_q;
    value_d     = value_q;
    digit_err_d = digit_err_q;
    valid_d     = 1'b0;

    unique case (state_q)
      StIdle: if (enable) state_d = StScan;
      StScan: if (!enable) begin
        state_d = StIdle;
        seen_d  = 4'h0;
      end
      default: state_d = StIdle;
    endcase

    // Publish the frame assembled so far; a write on this same edge starts the next one.
    if (complete) begin
      value_d     = slots_q;
      digit_err_d = err_q;
      valid_d     = 1'b1;
      seen_d      = 4'h0;
    end

    if (write_en) begin
      for (int i = 0; i < 4; i++) begin
        if (!stage_anode_q[i]) begin
          slots_d[4*i +: 4] = dec;
          err_d[i]          = dec_bad;
          seen_d[i]         = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      stage_anode_q <= 4'hF;
      stage_seg_q   <= 7'h7F;
      cnt_q         <= '0;
      seen_q        <= 4'h0;
      slots_q       <= 16'h0000;
      err_q         <= 4'h0;
      value_q       <= 16'h0000;
      digit_err_q   <= 4'h0;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      stage_anode_q <= anode_n;
      stage_seg_q   <= LED_out;
      cnt_q         <= cnt_d;
      seen_q        <= seen_d;
      slots_q       <= slots_d;
      err_q         <= err_d;
      value_q       <= value_d;
      digit_err_q   <= digit_err_d;
      valid_q       <= valid_d;
    end
  end

  assign value     = value_q;
  assign digit_err = digit_err_q;
  assign valid     = valid_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: directed scenarios plus a randomized segment stream
// checked against an event-level model of qualification and frame assembly.
module tb_seg_scan_capture;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  anode_n;
  logic [0:6]  LED_out;
  logic [15:0] value;
  logic [3:0]  digit_err;
  logic        valid;

  always #5 clk = ~clk;

  seg_scan_capture #(.STABLE_CYCLES(S), .CNT_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .anode_n   (anode_n),
    .LED_out   (LED_out),
    .value     (value),
    .digit_err (digit_err),
    .valid     (valid)
  );

  int total = 0;
  int bad   = 0;
  int ec    = 0;
  int last_start;

  logic [6:0] pat [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                           7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  logic [15:0] fv[$];
  logic [3:0]  fe[$];
  int          fc[$];
  logic [10:0] run_val[$];
  int          run_start[$];

  always @(posedge clk) ec <= ec + 1;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      fv.push_back(value);
      fe.push_back(digit_err);
      fc.push_back(ec);
    end
  end

  task automatic clear_mon();
    fv.delete();
    fe.delete();
    fc.delete();
  endtask

  // Drive a bus value right after edge ec; stage sees it on edges ec+1 .. ec+h.
  task automatic show(input logic [3:0] a, input logic [6:0] s, input int h);
    anode_n = a;
    LED_out = s;
    last_start = ec;
    run_val.push_back({a, s});
    run_start.push_back(ec);
    repeat (h) @(negedge clk);
  endtask

  task automatic digit(input int pos, input int d, input int h);
    logic [3:0] a;
    a = 4'hF;
    a[pos] = 1'b0;
    show(a, pat[d], h);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    enable  = 1'b0;
    anode_n = 4'hF;
    LED_out = 7'h7F;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic start_scan();
    enable = 1'b1;
    show(4'hF, 7'h7F, 2);
    clear_mon();
  endtask

  task automatic test_reset();
    total++; if (value !== 16'h0000) begin bad++; $display("FAIL reset_value got=%h want=0000", value); end
    total++; if (digit_err !== 4'h0) begin bad++; $display("FAIL reset_err got=%b want=0000", digit_err); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
    reset = 1'b0;
    clear_mon();
    repeat (8) @(negedge clk);
    total++; if (fv.size() != 0) begin bad++; $display("FAIL idle_frames got=%0d want=0", fv.size()); end
    total++; if (value !== 16'h0000) begin bad++; $display("FAIL idle_value got=%h want=0000", value); end
  endtask

  task automatic test_basic_scan();
    int t;
    do_reset();
    start_scan();
    digit(3, 1, 8); digit(2, 2, 8); digit(1, 3, 8); digit(0, 4, 8);
    t = last_start;
    show(4'hF, 7'h7F, 8);
    total++; if (fv.size() != 1) begin bad++; $display("FAIL basic_count got=%0d want=1", fv.size()); end
    total++; if (((fv.size() > 0) ? fv[0] : 16'hxxxx) !== 16'h1234) begin
      bad++; $display("FAIL basic_value got=%h want=1234", (fv.size() > 0) ? fv[0] : 16'hxxxx);
    end
    total++; if (((fe.size() > 0) ? fe[0] : 4'hx) !== 4'h0) begin
      bad++; $display("FAIL basic_err got=%b want=0000", (fe.size() > 0) ? fe[0] : 4'hx);
    end
    total++; if (((fc.size() > 0) ? fc[0] : -1) != t + S + 2) begin
      bad++; $display("FAIL basic_latency got=%0d want=%0d", (fc.size() > 0) ? fc[0] : -1, t + S + 2);
    end
  endtask

  task automatic test_short_hold();
    do_reset();
    start_scan();
    digit(3, 6, 8); digit(2, 7, 8); digit(1, 8, 8); digit(0, 9, 3);
    show(4'hF, 7'h7F, 12);
    total++; if (fv.size() != 0) begin bad++; $display("FAIL short_count got=%0d want=0", fv.size()); end
    total++; if (value !== 16'h0000) begin bad++; $display("FAIL short_value got=%h want=0000", value); end
  endtask

  task automatic test_bad_pattern();
    do_reset();
    start_scan();
    digit(3, 5, 8); show(4'b1011, 7'h7F, 8); digit(1, 5, 8); digit(0, 5, 8);
    show(4'hF, 7'h7F, 8);
    total++; if (fv.size() != 1) begin bad++; $display("FAIL badpat_count got=%0d want=1", fv.size()); end
    total++; if (value !== 16'h5F55) begin bad++; $display("FAIL badpat_value got=%h want=5f55", value); end
    total++; if (digit_err !== 4'b0100) begin bad++; $display("FAIL badpat_err got=%b want=0100", digit_err); end
  endtask

  task automatic test_glitch();
    do_reset();
    start_scan();
    show(4'b0011, pat[8], 10);
    digit(3, 9, 8); digit(2, 8, 8); digit(1, 7, 8); digit(0, 6, 8);
    show(4'hF, 7'h7F, 8);
    total++; if (fv.size() != 1) begin bad++; $display("FAIL glitch_count got=%0d want=1", fv.size()); end
    total++; if (value !== 16'h9876) begin bad++; $display("FAIL glitch_value got=%h want=9876", value); end
    total++; if (digit_err !== 4'h0) begin bad++; $display("FAIL glitch_err got=%b want=0000", digit_err); end
  endtask

  task automatic test_reset_midframe();
    digit(3, 1, 8); digit(2, 2, 8);
    do_reset();
    total++; if (value !== 16'h0000) begin bad++; $display("FAIL midrst_value got=%h want=0000", value); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", valid); end
    start_scan();
    digit(1, 2, 8); digit(0, 1, 8);
    show(4'hF, 7'h7F, 8);
    total++; if (fv.size() != 0) begin bad++; $display("FAIL midrst_partial got=%0d want=0", fv.size()); end
    digit(3, 4, 8); digit(2, 3, 8); digit(1, 2, 8); digit(0, 1, 8);
    show(4'hF, 7'h7F, 8);
    total++; if (fv.size() != 1) begin bad++; $display("FAIL midrst_count got=%0d want=1", fv.size()); end
    total++; if (value !== 16'h4321) begin bad++; $display("FAIL midrst_value2 got=%h want=4321", value); end
  endtask

  task automatic test_enable_drop();
    do_reset();
    start_scan();
    digit(3, 7, 8); digit(2, 8, 8); digit(1, 9, 8);
    // Enable falls on the very edge digit 0 would qualify.
    digit(0, 3, 4);
    enable = 1'b0;
    repeat (6) @(negedge clk);
    enable = 1'b1;
    show(4'hF, 7'h7F, 2);
    digit(0, 3, 8);
    show(4'hF, 7'h7F, 8);
    total++; if (fv.size() != 0) begin bad++; $display("FAIL endrop_count got=%0d want=0", fv.size()); end
    total++; if (value !== 16'h0000) begin bad++; $display("FAIL endrop_value got=%h want=0000", value); end
    digit(3, 6, 8); digit(2, 5, 8); digit(1, 4, 8); digit(0, 3, 8);
    show(4'hF, 7'h7F, 8);
    total++; if (fv.size() != 1) begin bad++; $display("FAIL endrop_count2 got=%0d want=1", fv.size()); end
    total++; if (value !== 16'h6543) begin bad++; $display("FAIL endrop_value2 got=%h want=6543", value); end
  endtask

  task automatic test_random();
    logic [15:0] xv[$];
    logic [3:0]  xe[$];
    int          xc[$];
    logic [3:0]  seen, errs, a;
    logic [15:0] slots;
    logic [6:0]  s;
    int i, j, en, pos, d, n;
    do_reset();
    enable = 1'b1;
    run_val.delete();
    run_start.delete();
    show(4'hF, 7'h7F, 3);
    clear_mon();
    for (int k = 0; k < 150; k++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 70) begin a = 4'hF; a[$urandom_range(0, 3)] = 1'b0; end
      else if (r < 85) a = 4'hF;
      else a = 4'($urandom);
      s = ($urandom_range(0, 99) < 80) ? pat[$urandom_range(0, 9)] : 7'($urandom);
      show(a, s, $urandom_range(1, 9));
    end
    show(4'hF, 7'h7F, 12);

    // Each maximal run of one bus value qualifies once if it lasts at least S+1 edges.
    seen = 4'h0; errs = 4'h0; slots = 16'h0; n = run_val.size(); i = 0;
    while (i < n) begin
      j = i + 1;
      while (j < n && run_val[j] == run_val[i]) j++;
      en = (j < n) ? run_start[j] : ec;
      a = run_val[i][10:7];
      s = run_val[i][6:0];
      if (en - run_start[i] >= S + 1 && $countones(~a) == 1) begin
        pos = 0;
        for (int b = 0; b < 4; b++) if (!a[b]) pos = b;
        d = 15;
        for (int p = 0; p < 10; p++) if (pat[p] == s) d = p;
        slots[4*pos +: 4] = 4'(d);
        errs[pos] = (d == 15);
        seen[pos] = 1'b1;
        if (seen == 4'hF) begin
          xv.push_back(slots); xe.push_back(errs); xc.push_back(run_start[i] + S + 2);
          seen = 4'h0;
        end
      end
      i = j;
    end

    total++; if (fv.size() != xv.size()) begin
      bad++; $display("FAIL rand_count got=%0d want=%0d", fv.size(), xv.size());
    end
    for (int k = 0; k < xv.size() && k < fv.size(); k++) begin
      total++; if (fv[k] !== xv[k]) begin bad++; $display("FAIL rand_value[%0d] got=%h want=%h", k, fv[k], xv[k]); end
      total++; if (fe[k] !== xe[k]) begin bad++; $display("FAIL rand_err[%0d] got=%b want=%b", k, fe[k], xe[k]); end
      total++; if (fc[k] != xc[k]) begin bad++; $display("FAIL rand_edge[%0d] got=%0d want=%0d", k, fc[k], xc[k]); end
    end
  endtask

  initial begin
    reset   = 1'b1;
    enable  = 1'b0;
    anode_n = 4'hF;
    LED_out = 7'h7F;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic_scan();
    test_short_hold();
    test_bad_pattern();
    test_glitch();
    test_reset_midframe();
    test_enable_drop();
    for (int r = 0; r < 3; r++) test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
